// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory read port plus the decode-facing
// instruction stream and the execute redirect request.
interface instruction_fetch_unit_if;
    logic [31:0] IMEM_ADDRESS;
    logic        IMEM_READ;
    logic [31:0] IMEM_READ_DATA;
    logic        IMEM_BUSYWAIT;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        INSTR_READY;
    logic        INSTR_VALID;
    logic [31:0] INSTR;
    logic [31:0] INSTR_PC;
    logic        MISALIGNED;

    modport master (
        output IMEM_ADDRESS, IMEM_READ, INSTR_VALID, INSTR, INSTR_PC, MISALIGNED,
        input  IMEM_READ_DATA, IMEM_BUSYWAIT, REDIRECT, REDIRECT_PC, INSTR_READY
    );

    modport slave (
        input  IMEM_ADDRESS, IMEM_READ, INSTR_VALID, INSTR, INSTR_PC, MISALIGNED,
        output IMEM_READ_DATA, IMEM_BUSYWAIT, REDIRECT, REDIRECT_PC, INSTR_READY
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: word-aligned reads with a BUSYWAIT handshake, a small prefetch
// queue of {pc, instr}, and redirect handling that discards in-flight data.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    instruction_fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {FETCH, WAIT, KILL} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   pend_q, pend_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          started_q;
    logic          misaligned_q, misaligned_d;
    logic [31:0]   que_pc_q    [DEPTH];
    logic [31:0]   que_instr_q [DEPTH];

    logic          req, xfer, stall, push, pop;
    logic [31:0]   target;

    // KILL keeps requesting the old address so the in-flight transfer can finish.
    assign req    = started_q && ((state_q == KILL) || (count_q < CW'(DEPTH)));
    assign xfer   = req && !bus.IMEM_BUSYWAIT;
    assign stall  = req && bus.IMEM_BUSYWAIT;
    assign target = {bus.REDIRECT_PC[31:2], 2'b00};
    assign push   = xfer && (state_q != KILL) && !bus.REDIRECT;
    assign pop    = (count_q != '0) && bus.INSTR_READY && !bus.REDIRECT;

    always_comb begin
        state_d      = state_q;
        fpc_d        = fpc_q;
        pend_d       = pend_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        misaligned_d = 1'b0;
        if (bus.REDIRECT) begin
            misaligned_d = (bus.REDIRECT_PC[1:0] != 2'b00);
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            // A transfer still pending must be allowed to finish before the jump.
            if (stall) begin
                state_d = KILL;
                pend_d  = target;
            end else begin
                state_d = FETCH;
                fpc_d   = target;
            end
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            unique case (state_q)
                FETCH: begin
                    if (xfer)       fpc_d   = fpc_q + 32'd4;
                    else if (stall) state_d = WAIT;
                end
                WAIT: begin
                    if (xfer) begin
                        fpc_d   = fpc_q + 32'd4;
                        state_d = FETCH;
                    end
                end
                KILL: begin
                    if (xfer) begin
                        fpc_d   = pend_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= FETCH;
            fpc_q        <= RESET_PC;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            started_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fpc_q        <= fpc_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            started_q    <= 1'b1;
            misaligned_q <= misaligned_d;
        end
    end

    always_ff @(posedge CLK) begin
        pend_q <= pend_d;
        if (push) begin
            que_pc_q[wr_ptr_q]    <= fpc_q;
            que_instr_q[wr_ptr_q] <= bus.IMEM_READ_DATA;
        end
    end

    assign bus.IMEM_ADDRESS = fpc_q;
    assign bus.IMEM_READ    = req;
    assign bus.INSTR_VALID  = (count_q != '0);
    assign bus.INSTR        = (count_q != '0) ? que_instr_q[rd_ptr_q] : '0;
    assign bus.INSTR_PC     = (count_q != '0) ? que_pc_q[rd_ptr_q] : '0;
    assign bus.MISALIGNED   = misaligned_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: stimulus queues expected
// {pc, instr, spacing}; a monitor drives INSTR_READY and checks each delivery.
module tb_instruction_fetch_unit;
    logic CLK;
    logic RESET;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          gap;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_cmp;
    int          n_bad;
    int          cyc;
    int          last_cyc;
    int          lat;
    int          wleft;
    logic        ready_en;
    logic        stall_en;
    logic [31:0] stall_addr;
    logic        prev_rd;
    logic        prev_bw;
    logic [31:0] prev_addr;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input int gap);
        exp_t x;
        x.pc    = pc;
        x.instr = instr;
        x.gap   = gap;
        sb.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick(1);
        n_cmp = n_cmp + 1;
        if (sb.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain_timeout: %0d deliveries outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(2);
        chk1 ("rst_imem_read",   bus.IMEM_READ,    1'b0);
        chk1 ("rst_instr_valid", bus.INSTR_VALID,  1'b0);
        chk1 ("rst_misaligned",  bus.MISALIGNED,   1'b0);
        chk32("rst_imem_addr",   bus.IMEM_ADDRESS, 32'h0000_0000);
        chk32("rst_instr",       bus.INSTR,        32'h0000_0000);
        chk32("rst_instr_pc",    bus.INSTR_PC,     32'h0000_0000);
        RESET = 1'b0;
        #1;
        chk1("read_before_start", bus.IMEM_READ, 1'b0);
        tick(1);
        chk1("read_after_edge0", bus.IMEM_READ, 1'b1);
    endtask

    // Memory responder: `lat` busy cycles per read, optional stall on one address.
    initial begin
        wleft     = -1;
        prev_rd   = 1'b0;
        prev_bw   = 1'b0;
        prev_addr = '0;
        bus.IMEM_BUSYWAIT  = 1'b0;
        bus.IMEM_READ_DATA = '0;
        forever begin
            @(negedge CLK);
            if (prev_rd && prev_bw && !RESET) begin
                chk1 ("hold_read", bus.IMEM_READ,    1'b1);
                chk32("hold_addr", bus.IMEM_ADDRESS, prev_addr);
            end
            if (prev_rd && !prev_bw) wleft = -1;
            if (!bus.IMEM_READ)      wleft = -1;
            else if (wleft < 0)      wleft = lat;
            else if (wleft > 0)      wleft = wleft - 1;
            bus.IMEM_BUSYWAIT  = (wleft > 0) || (stall_en && (bus.IMEM_ADDRESS == stall_addr));
            bus.IMEM_READ_DATA = mem_word(bus.IMEM_ADDRESS);
            prev_rd   = bus.IMEM_READ;
            prev_bw   = bus.IMEM_BUSYWAIT;
            prev_addr = bus.IMEM_ADDRESS;
        end
    end

    // Monitor: accept only while deliveries are expected, compare in order.
    initial begin
        bus.INSTR_READY = 1'b0;
        last_cyc = 0;
        forever begin
            @(negedge CLK);
            bus.INSTR_READY = ready_en && (sb.size() != 0);
            if (bus.INSTR_VALID && bus.INSTR_READY && !bus.REDIRECT && !RESET) begin
                e = sb.pop_front();
                chk32("instr_pc", bus.INSTR_PC, e.pc);
                chk32("instr",    bus.INSTR,    e.instr);
                if (e.gap != 0) chk32("instr_spacing", cyc - last_cyc, e.gap);
                last_cyc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        RESET = 1'b1;
        bus.REDIRECT    = 1'b0;
        bus.REDIRECT_PC = '0;
        ready_en   = 1'b0;
        lat        = 0;
        stall_en   = 1'b0;
        stall_addr = '0;

        // Zero-wait streaming, one instruction per cycle.
        lat = 0; ready_en = 1'b1;
        push_exp(32'h0000_0000, 32'hC0DE_0000, 0);
        push_exp(32'h0000_0004, 32'hC0DE_0004, 1);
        push_exp(32'h0000_0008, 32'hC0DE_0008, 1);
        push_exp(32'h0000_000C, 32'hC0DE_000C, 1);
        push_exp(32'h0000_0010, 32'hC0DE_0010, 1);
        do_reset();
        wait_empty(50);

        // Three busy cycles per read: one instruction every four cycles.
        lat = 3; ready_en = 1'b1;
        push_exp(32'h0000_0000, 32'hC0DE_0000, 0);
        push_exp(32'h0000_0004, 32'hC0DE_0004, 4);
        push_exp(32'h0000_0008, 32'hC0DE_0008, 4);
        push_exp(32'h0000_000C, 32'hC0DE_000C, 4);
        do_reset();
        wait_empty(100);

        // Decode stalled: queue fills, fetch stops, order kept on release.
        lat = 0; ready_en = 1'b0;
        do_reset();
        tick(10);
        chk1 ("full_read_drop", bus.IMEM_READ,   1'b0);
        chk1 ("full_valid",     bus.INSTR_VALID, 1'b1);
        chk32("full_head_pc",   bus.INSTR_PC,    32'h0000_0000);
        push_exp(32'h0000_0000, 32'hC0DE_0000, 0);
        push_exp(32'h0000_0004, 32'hC0DE_0004, 1);
        push_exp(32'h0000_0008, 32'hC0DE_0008, 1);
        ready_en = 1'b1;
        wait_empty(50);

        // Redirect while the read of address 8 is stuck busy.
        lat = 0; ready_en = 1'b1; stall_en = 1'b1; stall_addr = 32'h0000_0008;
        push_exp(32'h0000_0000, 32'hC0DE_0000, 0);
        push_exp(32'h0000_0004, 32'hC0DE_0004, 1);
        do_reset();
        wait_empty(50);
        tick(3);
        chk32("stall_addr", bus.IMEM_ADDRESS, 32'h0000_0008);
        chk1 ("stall_read", bus.IMEM_READ,    1'b1);
        bus.REDIRECT = 1'b1; bus.REDIRECT_PC = 32'h0000_0100;
        push_exp(32'h0000_0100, 32'hC0DE_0100, 0);
        push_exp(32'h0000_0104, 32'hC0DE_0104, 1);
        tick(1);
        bus.REDIRECT = 1'b0;
        chk32("kill_addr",  bus.IMEM_ADDRESS, 32'h0000_0008);
        chk1 ("kill_valid", bus.INSTR_VALID,  1'b0);
        chk1 ("kill_read",  bus.IMEM_READ,    1'b1);
        chk1 ("kill_misaligned", bus.MISALIGNED, 1'b0);
        tick(2);
        chk32("kill_addr_late", bus.IMEM_ADDRESS, 32'h0000_0008);
        stall_en = 1'b0;
        wait_empty(50);

        // Misaligned redirect target, zero-wait memory: one bubble cycle.
        lat = 0; ready_en = 1'b1;
        push_exp(32'h0000_0000, 32'hC0DE_0000, 0);
        push_exp(32'h0000_0004, 32'hC0DE_0004, 1);
        do_reset();
        wait_empty(50);
        tick(2);
        bus.REDIRECT = 1'b1; bus.REDIRECT_PC = 32'h0000_0102;
        push_exp(32'h0000_0100, 32'hC0DE_0100, 0);
        push_exp(32'h0000_0104, 32'hC0DE_0104, 1);
        tick(1);
        bus.REDIRECT = 1'b0;
        chk1 ("misaligned_pulse", bus.MISALIGNED,   1'b1);
        chk32("redirect_addr",    bus.IMEM_ADDRESS, 32'h0000_0100);
        chk1 ("redirect_bubble",  bus.INSTR_VALID,  1'b0);
        tick(1);
        chk1 ("misaligned_clear", bus.MISALIGNED,   1'b0);
        chk1 ("redirect_valid",   bus.INSTR_VALID,  1'b1);
        chk32("redirect_head_pc", bus.INSTR_PC,     32'h0000_0100);
        wait_empty(50);

        // Asynchronous reset in the middle of a busy read.
        lat = 3; ready_en = 1'b0;
        do_reset();
        tick(6);
        chk1("midwait_read",  bus.IMEM_READ,   1'b1);
        chk1("midwait_valid", bus.INSTR_VALID, 1'b1);
        RESET = 1'b1;
        #1;
        chk1 ("async_rst_read",  bus.IMEM_READ,    1'b0);
        chk1 ("async_rst_valid", bus.INSTR_VALID,  1'b0);
        chk32("async_rst_addr",  bus.IMEM_ADDRESS, 32'h0000_0000);
        lat = 0; ready_en = 1'b1;
        push_exp(32'h0000_0000, 32'hC0DE_0000, 0);
        push_exp(32'h0000_0004, 32'hC0DE_0004, 1);
        do_reset();
        wait_empty(50);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
